vram_wr_arb: RTL and testbench
==============================

VRAM_WR_ARB -- requirements
Module: vram_wr_arb

Interface
REQ-001 SHALL have parameter SCREEN_CELLS, default 2000, the number of valid cells (80x25); addresses 0..SCREEN_CELLS-1.
REQ-002 SHALL have parameter CLR_CHAR, default 8'h20, the character code written by the clear engine.
REQ-003 SHALL have parameter CLR_ATTR, default 8'h07, the color attribute written by the clear engine.
REQ-004 SHALL have port i_clk  in  1  system clock (pixel clock domain); all logic rising-edge.
REQ-005 SHALL have port i_rst_l  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port i_a_req_h  in  1  requester A (SPI bridge) write request.
REQ-007 SHALL have ports i_a_adr, i_a_chr and i_a_attr  in  11/8/8  requester A cell address, character and attribute.
REQ-008 SHALL have port o_a_ack_h  out  1  one-cycle pulse: A's write accepted.
REQ-009 SHALL have ports i_b_req_h, i_b_adr, i_b_chr, i_b_attr and o_b_ack_h, identical to A, for requester B (DMA char writer).
REQ-010 SHALL have port i_clr_start_h  in  1  start the full-screen clear.
REQ-011 SHALL have port o_clr_busy_h  out  1  clear engine active.
REQ-012 SHALL have port o_vram_adr  out  11  write address to the video and color RAM.
REQ-013 SHALL have ports o_vram_data and o_cram_data  out  8/8  character and attribute write data.
REQ-014 SHALL have port o_vram_wr_h  out  1  write strobe for both RAMs, one cycle per write.
REQ-015 SHALL have port o_oor_h  out  1  one-cycle pulse: accepted request had an address >= SCREEN_CELLS.

Function
REQ-016 SHALL register all outputs; no combinational input-to-output path.
REQ-017 SHALL be eligible for requester X at edge N only if i_x_req_h=1, o_x_ack_h=0 in cycle N (one dead cycle after each ack) and the FSM is IDLE.
REQ-018 SHALL apply this priority at each edge: clear engine > round-robin between eligible A/B; at most one write per cycle.
REQ-019 SHALL grant A and B round-robin: with both eligible, grant the one not granted last; last_grant updates only on a grant.
REQ-020 SHALL, on a grant at edge N, in cycle N+1 drive o_x_ack_h=1 and o_vram_adr/o_vram_data/o_cram_data = the captured adr/chr/attr, with o_vram_wr_h=1 (latency 1).
REQ-021 SHALL, if a granted address is >= SCREEN_CELLS, still pulse ack, hold o_vram_wr_h=0 and pulse o_oor_h=1 in cycle N+1.
REQ-022 SHALL require requesters to hold req/adr/chr/attr stable until ack; a req still high after the dead cycle is a new request.
REQ-023 SHALL have FSM states IDLE and CLEAR.
REQ-024 SHALL transition IDLE->CLEAR when i_clr_start_h=1; i_clr_start_h is ignored in CLEAR.
REQ-025 SHALL, in CLEAR, write one cell per cycle at addresses 0,1,...,SCREEN_CELLS-1 with CLR_CHAR/CLR_ATTR and o_vram_wr_h=1.
REQ-026 SHALL transition CLEAR->IDLE after the write to address SCREEN_CELLS-1; the clear takes exactly SCREEN_CELLS strobe cycles.
REQ-027 SHALL hold o_clr_busy_h=1 from the cycle after the start edge through the last clear write cycle.
REQ-028 SHALL, while busy, issue no acks; pending A/B requests wait and are served round-robin after return to IDLE.
REQ-029 SHALL, when start and A/B requests coincide at one edge, start the clear and grant neither.
REQ-030 SHALL use an 11-bit clear counter that stops at SCREEN_CELLS-1 and never wraps.
REQ-031 SHALL make o_vram_wr_h, ack and o_oor_h single-cycle pulses; address and data outputs hold their last values when idle.

Reset
REQ-032 SHALL, while i_rst_l=0, force: all acks, o_vram_wr_h, o_oor_h and o_clr_busy_h = 0; o_vram_adr = 0; data outputs = 0; FSM = IDLE; clear counter = 0; last_grant = B (so A wins the first tie).
REQ-033 SHALL, on reset mid-clear, abort the clear with no further writes; after release, not resume the clear and return to IDLE.
REQ-034 SHALL take the first grant no earlier than the first rising edge after i_rst_l deasserts.

Verification
REQ-035 SHALL cover: after reset, A req adr=5 chr=0x41 attr=0x1E -> next cycle wr=1, adr=5, data=0x41, cram=0x1E, a_ack=1.
REQ-036 SHALL cover: A and B held continuously -> grants alternate A,B,A,B; each requester sees ack at most every 2nd cycle.
REQ-037 SHALL cover: clear start pulse -> busy for 2000 cycles, writes 0..1999 of 0x20/0x07, then busy=0.
REQ-038 SHALL cover: B requests during clear -> no b_ack until busy=0, then b_ack in the first IDLE grant cycle.
REQ-039 SHALL cover: A adr=2000 -> a_ack=1, o_oor_h=1, o_vram_wr_h=0.
REQ-040 SHALL cover: i_rst_l pulled low at clear address 700 -> outputs zero, and after release no writes without a new request.

Source files
------------

// File: rtl/vram_wr_arb.sv
// Write arbiter for the text-mode video/color RAM: a full-screen clear engine
// takes priority over two round-robin requesters, one registered write per cycle.
module vram_wr_arb #(
  parameter int         SCREEN_CELLS = 2000,
  parameter logic [7:0] CLR_CHAR     = 8'h20,
  parameter logic [7:0] CLR_ATTR     = 8'h07
) (
  input  logic        i_clk,
  input  logic        i_rst_l,
  input  logic        i_a_req_h,
  input  logic [10:0] i_a_adr,
  input  logic [7:0]  i_a_chr,
  input  logic [7:0]  i_a_attr,
  output logic        o_a_ack_h,
  input  logic        i_b_req_h,
  input  logic [10:0] i_b_adr,
  input  logic [7:0]  i_b_chr,
  input  logic [7:0]  i_b_attr,
  output logic        o_b_ack_h,
  input  logic        i_clr_start_h,
  output logic        o_clr_busy_h,
  output logic [10:0] o_vram_adr,
  output logic [7:0]  o_vram_data,
  output logic [7:0]  o_cram_data,
  output logic        o_vram_wr_h,
  output logic        o_oor_h
);

  // Handshake: a requester raises req with stable adr/chr/attr and holds them
  // until it sees a one-cycle ack; the cycle of the ack is dead for that
  // requester, so a req still high in the following cycle is a new request.

  localparam logic [10:0] LAST_ADR = 11'(SCREEN_CELLS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] clr_cnt_q, clr_cnt_d;
  logic        last_b_q, last_b_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        busy_q, busy_d;
  logic        wr_q, wr_d;
  logic        oor_q, oor_d;
  logic [10:0] adr_q, adr_d;
  logic [7:0]  chr_q, chr_d;
  logic [7:0]  attr_q, attr_d;

  logic elig_a, elig_b, grant_a, grant_b;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    last_b_d  = last_b_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    busy_d    = busy_q;
    wr_d      = 1'b0;
    oor_d     = 1'b0;
    adr_d     = adr_q;
    chr_d     = chr_q;
    attr_d    = attr_q;
    elig_a    = i_a_req_h & ~a_ack_q;
    elig_b    = i_b_req_h & ~b_ack_q;
    grant_a   = 1'b0;
    grant_b   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_clr_start_h) begin
          // First clear write goes out on the start edge itself.
          state_d   = ST_CLEAR;
          clr_cnt_d = 11'd0;
          busy_d    = 1'b1;
          wr_d      = 1'b1;
          adr_d     = 11'd0;
          chr_d     = CLR_CHAR;
          attr_d    = CLR_ATTR;
        end else begin
          // On a tie, A wins only if B was granted last.
          grant_a = elig_a & (~elig_b | last_b_q);
          grant_b = elig_b & ~grant_a;
          if (grant_a | grant_b) begin
            last_b_d = grant_b;
            a_ack_d  = grant_a;
            b_ack_d  = grant_b;
            adr_d    = grant_a ? i_a_adr  : i_b_adr;
            chr_d    = grant_a ? i_a_chr  : i_b_chr;
            attr_d   = grant_a ? i_a_attr : i_b_attr;
            wr_d     = (adr_d <= LAST_ADR);
            oor_d    = ~wr_d;
          end
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_ADR) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          clr_cnt_d = clr_cnt_q + 11'd1;
          adr_d     = clr_cnt_d;
          chr_d     = CLR_CHAR;
          attr_d    = CLR_ATTR;
          wr_d      = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= 11'd0;
      last_b_q  <= 1'b1;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
      wr_q      <= 1'b0;
      oor_q     <= 1'b0;
      adr_q     <= 11'd0;
      chr_q     <= 8'd0;
      attr_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      last_b_q  <= last_b_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      busy_q    <= busy_d;
      wr_q      <= wr_d;
      oor_q     <= oor_d;
      adr_q     <= adr_d;
      chr_q     <= chr_d;
      attr_q    <= attr_d;
    end
  end

  assign o_a_ack_h    = a_ack_q;
  assign o_b_ack_h    = b_ack_q;
  assign o_clr_busy_h = busy_q;
  assign o_vram_wr_h  = wr_q;
  assign o_oor_h      = oor_q;
  assign o_vram_adr   = adr_q;
  assign o_vram_data  = chr_q;
  assign o_cram_data  = attr_q;

endmodule

// File: tb/tb_vram_wr_arb.sv
// Bench for vram_wr_arb: a cycle-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_vram_wr_arb;

  localparam int SC = 2000;

  logic        i_clk = 1'b0;
  logic        i_rst_l;
  logic        i_a_req_h, i_b_req_h, i_clr_start_h;
  logic [10:0] i_a_adr, i_b_adr;
  logic [7:0]  i_a_chr, i_a_attr, i_b_chr, i_b_attr;
  logic        o_a_ack_h, o_b_ack_h, o_clr_busy_h, o_vram_wr_h, o_oor_h;
  logic [10:0] o_vram_adr;
  logic [7:0]  o_vram_data, o_cram_data;

  int n_vec = 0;
  int n_err = 0;

  vram_wr_arb #(.SCREEN_CELLS(SC), .CLR_CHAR(8'h20), .CLR_ATTR(8'h07)) dut (
    .i_clk(i_clk), .i_rst_l(i_rst_l),
    .i_a_req_h(i_a_req_h), .i_a_adr(i_a_adr), .i_a_chr(i_a_chr), .i_a_attr(i_a_attr),
    .o_a_ack_h(o_a_ack_h),
    .i_b_req_h(i_b_req_h), .i_b_adr(i_b_adr), .i_b_chr(i_b_chr), .i_b_attr(i_b_attr),
    .o_b_ack_h(o_b_ack_h),
    .i_clr_start_h(i_clr_start_h), .o_clr_busy_h(o_clr_busy_h),
    .o_vram_adr(o_vram_adr), .o_vram_data(o_vram_data), .o_cram_data(o_cram_data),
    .o_vram_wr_h(o_vram_wr_h), .o_oor_h(o_oor_h)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] dut_vec, exp_vec;
  assign dut_vec = {o_a_ack_h, o_b_ack_h, o_vram_wr_h, o_oor_h, o_clr_busy_h,
                    o_vram_adr, o_vram_data, o_cram_data};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the clear is a count of remaining writes, arbitration
  // is read straight off the eligibility and last-winner rules.
  logic        e_a_ack = 0, e_b_ack = 0, e_wr = 0, e_oor = 0, e_busy = 0;
  logic [10:0] e_adr = 0;
  logic [7:0]  e_chr = 0, e_attr = 0;
  int          m_left = 0;
  logic        m_last_b = 1;
  assign exp_vec = {e_a_ack, e_b_ack, e_wr, e_oor, e_busy, e_adr, e_chr, e_attr};

  always @(posedge i_clk or negedge i_rst_l) begin : model
    logic pa, pb, ea, eb, ga, gb, do_clr;
    if (!i_rst_l) begin
      m_left = 0; m_last_b = 1;
      e_a_ack = 0; e_b_ack = 0; e_wr = 0; e_oor = 0; e_busy = 0;
      e_adr = 0; e_chr = 0; e_attr = 0;
    end else begin
      pa = e_a_ack; pb = e_b_ack;
      e_a_ack = 0; e_b_ack = 0; e_wr = 0; e_oor = 0;
      do_clr = 0;
      if (e_busy) begin
        if (m_left == 0) e_busy = 0;
        else do_clr = 1;
      end else if (i_clr_start_h) begin
        m_left = SC; e_busy = 1; do_clr = 1;
      end else begin
        ea = i_a_req_h && !pa;
        eb = i_b_req_h && !pb;
        if (ea && eb) begin ga = m_last_b; gb = !m_last_b; end
        else begin ga = ea; gb = eb; end
        if (ga || gb) begin
          e_a_ack = ga; e_b_ack = gb; m_last_b = gb;
          e_adr  = ga ? i_a_adr  : i_b_adr;
          e_chr  = ga ? i_a_chr  : i_b_chr;
          e_attr = ga ? i_a_attr : i_b_attr;
          e_wr   = (int'(e_adr) < SC);
          e_oor  = !e_wr;
        end
      end
      if (do_clr) begin
        e_adr = 11'(SC - m_left); e_chr = 8'h20; e_attr = 8'h07; e_wr = 1;
        m_left--;
      end
    end
  end

  always @(posedge i_clk) begin
    #1;
    check("cycle", dut_vec, exp_vec);
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic drv_a(input logic req, input logic [10:0] adr, input logic [7:0] chr, input logic [7:0] attr);
    i_a_req_h = req; i_a_adr = adr; i_a_chr = chr; i_a_attr = attr;
  endtask

  task automatic drv_b(input logic req, input logic [10:0] adr, input logic [7:0] chr, input logic [7:0] attr);
    i_b_req_h = req; i_b_adr = adr; i_b_chr = chr; i_b_attr = attr;
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cyc, n_wr;
    logic [10:0] first_adr, last_adr;
    logic saw_b;
    i_rst_l = 1'b0; i_clr_start_h = 1'b0;
    drv_a(0, 0, 0, 0); drv_b(0, 0, 0, 0);
    repeat (3) @(negedge i_clk);
    check("reset_outputs", dut_vec, 32'h0);
    i_rst_l = 1'b1;

    // Single A write right after reset.
    @(negedge i_clk); drv_a(1, 11'd5, 8'h41, 8'h1E);
    tick();
    check("a_wr", o_vram_wr_h, 1);
    check("a_adr", o_vram_adr, 5);
    check("a_data", o_vram_data, 8'h41);
    check("a_cram", o_cram_data, 8'h1E);
    check("a_ack", o_a_ack_h, 1);
    @(negedge i_clk); drv_a(0, 11'd5, 8'h41, 8'h1E);

    // Both held: A won last, so B takes the first tie, then strict alternation.
    @(negedge i_clk); drv_a(1, 11'd10, 8'h61, 8'h01); drv_b(1, 11'd20, 8'h62, 8'h02);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rr_a_ack", o_a_ack_h, (i % 2) == 1);
      check("rr_b_ack", o_b_ack_h, (i % 2) == 0);
      check("rr_adr", o_vram_adr, ((i % 2) == 1) ? 10 : 20);
    end
    @(negedge i_clk); drv_a(0, 0, 0, 0); drv_b(0, 0, 0, 0);

    // Out-of-range address, then the last valid cell.
    @(negedge i_clk); drv_a(1, 11'd2000, 8'h55, 8'h66);
    tick();
    check("oor_ack", o_a_ack_h, 1);
    check("oor_flag", o_oor_h, 1);
    check("oor_wr", o_vram_wr_h, 0);
    @(negedge i_clk); drv_a(0, 0, 0, 0);
    @(negedge i_clk); drv_a(1, 11'd1999, 8'h11, 8'h22);
    tick();
    check("last_cell_wr", o_vram_wr_h, 1);
    check("last_cell_oor", o_oor_h, 0);
    check("last_cell_adr", o_vram_adr, 1999);
    @(negedge i_clk); drv_a(0, 0, 0, 0);

    // Full clear; B requests mid-clear and a second start pulse is ignored.
    @(negedge i_clk); i_clr_start_h = 1'b1;
    tick();
    cyc = 0; n_wr = 0; saw_b = 0; first_adr = '1; last_adr = '1;
    while (o_clr_busy_h && cyc < 2100) begin
      if (o_vram_wr_h) begin
        if (n_wr == 0) first_adr = o_vram_adr;
        last_adr = o_vram_adr;
        n_wr++;
      end
      if (o_b_ack_h) saw_b = 1;
      cyc++;
      @(negedge i_clk);
      if (cyc == 1)   i_clr_start_h = 1'b0;
      if (cyc == 100) drv_b(1, 11'd300, 8'h42, 8'h03);
      if (cyc == 500) i_clr_start_h = 1'b1;
      if (cyc == 501) i_clr_start_h = 1'b0;
      tick();
    end
    check("clr_cycles", cyc, 2000);
    check("clr_writes", n_wr, 2000);
    check("clr_first_adr", first_adr, 0);
    check("clr_last_adr", last_adr, 1999);
    check("clr_no_b_ack", saw_b, 0);
    check("clr_idle_b_ack0", o_b_ack_h, 0);
    tick();
    check("post_clr_b_ack", o_b_ack_h, 1);
    check("post_clr_b_adr", o_vram_adr, 300);
    check("post_clr_b_data", o_vram_data, 8'h42);
    @(negedge i_clk); drv_b(0, 0, 0, 0);

    // Start coinciding with an A request, then reset at clear address 700.
    @(negedge i_clk); i_clr_start_h = 1'b1; drv_a(1, 11'd7, 8'h01, 8'h01);
    tick();
    check("coinc_busy", o_clr_busy_h, 1);
    check("coinc_no_ack", o_a_ack_h, 0);
    check("coinc_adr", o_vram_adr, 0);
    @(negedge i_clk); i_clr_start_h = 1'b0;
    cyc = 0;
    while (o_vram_adr != 11'd700 && cyc < 1000) begin tick(); cyc++; end
    check("reach_700", o_vram_adr, 700);
    @(negedge i_clk); i_rst_l = 1'b0; drv_a(0, 0, 0, 0);
    #1;
    check("midclr_reset", dut_vec, 32'h0);
    repeat (3) @(negedge i_clk);
    i_rst_l = 1'b1;
    n_wr = 0;
    repeat (20) begin tick(); if (o_vram_wr_h) n_wr++; end
    check("no_resume_writes", n_wr, 0);
    check("no_resume_busy", o_clr_busy_h, 0);

    // Arbiter still serves requests afterwards.
    @(negedge i_clk); drv_b(1, 11'd1, 8'h7A, 8'h4F);
    tick();
    check("final_b_ack", o_b_ack_h, 1);
    check("final_b_adr", o_vram_adr, 1);
    @(negedge i_clk); drv_b(0, 0, 0, 0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
